conv2d_stream: RTL

Streaming 2-D convolution engine for the CNN datapath. It consumes a raster-order pixel stream of `CH` parallel input channels and applies a `K`×`K` kernel per channel with stride `S`. It sums across channels, adds bias, and rescales fixed-point with saturation and optional ReLU. Results are emitted on a valid/ready output stream with end-of-frame marking. It is the parametrised, back-pressurable successor to the single-channel `ce`-driven convolver, and sits between the input/line-feed stage and the pooling stage.

---
 rtl/conv2d_stream_if.sv | 24 ++
 rtl/conv2d_stream.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/conv2d_stream_if.sv
// Valid/ready stream pair for conv2d_stream: pixel beats in, convolution results out.
// slave is the engine side, master is the producer/consumer side.
interface conv2d_stream_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [OUT_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/conv2d_stream.sv
// Streaming multi-channel KxK convolution with stride, bias, fixed-point rescale,
// saturation and optional ReLU. Two registered stages behind a single stall signal.
module conv2d_stream #(
   parameter int DATA_W = 16,
   parameter int FRAC   = 8,
   parameter int W      = 28,
   parameter int H      = 28,
   parameter int K      = 3,
   parameter int S      = 1,
   parameter int CH     = 1,
   parameter int RELU   = 0
) (
   input  logic                      clk,
   input  logic                      global_rst,
   conv2d_stream_if.slave            bus,
   input  logic [CH*K*K*DATA_W-1:0]  weight,
   input  logic [DATA_W-1:0]         bias,
   output logic                      frame_done
);
   localparam int  CW     = $clog2(W + 1);
   localparam int  RW     = $clog2(H + 1);
   localparam int  PW     = 2 * DATA_W;
   localparam int  ACC_W  = PW + $clog2(CH * K * K);
   localparam int  LB_N   = (K > 1) ? K - 1 : 1;
   localparam bit  CFG_OK = (W >= K) && (H >= K);
   localparam int  OW     = CFG_OK ? (W - K) / S + 1 : 1;
   localparam int  OH     = CFG_OK ? (H - K) / S + 1 : 1;

   localparam logic [CW-1:0] COL_MAX   = CW'(W - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(K - 1 + (OW - 1) * S);
   localparam logic [CW-1:0] COL_S     = CW'(S);
   localparam logic [RW-1:0] ROW_MAX   = RW'(H - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(K - 1 + (OH - 1) * S);
   localparam logic [RW-1:0] ROW_S     = RW'(S);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   logic                     advance, accept, pos_ok, pos_last;
   logic [CW-1:0]            col;
   logic [RW-1:0]            row;
   logic                     p1_valid, p1_last;
   logic signed [DATA_W-1:0] bias_s;
   logic signed [DATA_W-1:0] pix     [CH];
   logic signed [DATA_W-1:0] coef    [CH][K][K];
   logic signed [DATA_W-1:0] lb      [LB_N][CH][W];
   logic signed [DATA_W-1:0] win     [CH][K][K];
   logic signed [DATA_W-1:0] win_nxt [CH][K][K];
   logic signed [PW-1:0]     prod    [CH][K][K];
   logic signed [ACC_W-1:0]  acc, shifted;
   logic signed [DATA_W-1:0] result;

   assign advance      = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = advance;
   assign accept       = bus.in_valid && advance;
   assign bias_s       = bias;

   assign pos_ok = CFG_OK && (col >= COL_FIRST) && (row >= ROW_FIRST)
                   && (((col - COL_FIRST) % COL_S) == '0)
                   && (((row - ROW_FIRST) % ROW_S) == '0);
   assign pos_last = pos_ok && (col == COL_LAST) && (row == ROW_LAST);

   // Window row 0 is the oldest line, column K-1 is the incoming pixel column.
   always_comb begin
      for (int c = 0; c < CH; c++) begin
         pix[c] = bus.in_data[c*DATA_W +: DATA_W];
         for (int r = 0; r < K; r++) begin
            for (int cc = 0; cc < K; cc++) begin
               coef[c][r][cc] = weight[(c*K*K + r*K + cc)*DATA_W +: DATA_W];
            end
            for (int cc = 0; cc < K - 1; cc++) begin
               win_nxt[c][r][cc] = win[c][r][cc+1];
            end
         end
         for (int r = 0; r < K - 1; r++) begin
            win_nxt[c][r][K-1] = lb[K-2-r][c][col];
         end
         win_nxt[c][K-1][K-1] = pix[c];
      end
   end

   // Line buffers, window and products carry no reset: outputs are gated by position.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int c = 0; c < CH; c++) begin
            if (K > 1) lb[0][c][col] <= pix[c];
            for (int i = 1; i < K - 1; i++) begin
               lb[i][c][col] <= lb[i-1][c][col];
            end
            for (int r = 0; r < K; r++) begin
               for (int cc = 0; cc < K; cc++) begin
                  win[c][r][cc]  <= win_nxt[c][r][cc];
                  prod[c][r][cc] <= PW'(win_nxt[c][r][cc]) * PW'(coef[c][r][cc]);
               end
            end
         end
      end
   end

   always_comb begin
      acc = ACC_W'(bias_s) <<< FRAC;
      for (int c = 0; c < CH; c++) begin
         for (int r = 0; r < K; r++) begin
            for (int cc = 0; cc < K; cc++) begin
               acc = acc + ACC_W'(prod[c][r][cc]);
            end
         end
      end
      shifted = acc >>> FRAC;
      if (shifted > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
      else if (shifted < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
      else                        result = shifted[DATA_W-1:0];
      if ((RELU != 0) && result[DATA_W-1]) result = '0;
   end

   always_ff @(posedge clk or negedge global_rst) begin
      if (!global_rst) begin
         col           <= '0;
         row           <= '0;
         p1_valid      <= 1'b0;
         p1_last       <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         frame_done <= bus.out_valid && bus.out_ready && bus.out_last;
         if (accept) begin
            if (col == COL_MAX) begin
               col <= '0;
               row <= (row == ROW_MAX) ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if (advance) begin
            p1_valid      <= accept && pos_ok;
            p1_last       <= accept && pos_last;
            bus.out_valid <= p1_valid;
            bus.out_data  <= result;
            bus.out_last  <= p1_last;
         end
      end
   end
endmodule
